// File: rtl/draw_pkg.sv
// Shared definitions for the drawing-puzzle round sequencer.
//   state_t      : round FSM states
//   COLOR_W/CELL_W : paper color width and cell-index width
//   BLANK        : color written to every cell at round start
//   LFSR_TAPS    : Fibonacci tap mask for x^8+x^6+x^5+x^4+1, shift-left form
//   SEED_*       : bit positions of the seed fields
//   seed_ok()    : a seed is usable when both colors are non-blank and distinct
package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEED,
    ST_PLAY,
    ST_CHECK,
    ST_SOLVED,
    ST_FAILED
  } state_t;

  localparam int COLOR_W = 3;
  localparam int CELL_W  = 4;
  localparam int NUM_CELLS = 1 << CELL_W;

  localparam logic [COLOR_W-1:0] BLANK = 3'b000;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int SEED_SHAPE_HI = 7;
  localparam int SEED_SHAPE_LO = 6;
  localparam int SEED_C1_HI    = 5;
  localparam int SEED_C1_LO    = 3;
  localparam int SEED_C2_HI    = 2;
  localparam int SEED_C2_LO    = 0;

  function automatic logic seed_ok(input logic [7:0] v);
    logic [COLOR_W-1:0] c1;
    logic [COLOR_W-1:0] c2;
    c1 = v[SEED_C1_HI:SEED_C1_LO];
    c2 = v[SEED_C2_HI:SEED_C2_LO];
    return (c1 != BLANK) && (c2 != BLANK) && (c1 != c2);
  endfunction

endpackage

// File: rtl/round_lfsr.sv
// 8-bit Fibonacci LFSR, steps every cycle, reloads INIT on reset.
//   Clk : clock
//   Rst : synchronous active-high reset, loads INIT
//   q   : current LFSR value (never all-zero for non-zero INIT)
module round_lfsr
  import draw_pkg::*;
#(
  parameter logic [7:0] INIT = 8'hA5
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [7:0] q
);

  // Shift left; feedback is the parity of the tapped bits (7,5,4,3),
  // which realises x^8+x^6+x^5+x^4+1 (maximal length, zero unreachable).
  always_ff @(posedge Clk) begin
    if (Rst) q <= INIT;
    else     q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/draw_round_ctrl.sv
// Round sequencer for the drawing puzzle.
// Clears the 16-cell paper at round start, picks a seed from the LFSR,
// forwards keypad paints while the round is live, runs the countdown and
// judges submissions, counting strikes until solved or failed.
//   Clk, Rst            : clock, synchronous active-high reset
//   start               : begin a round (honoured in IDLE/SOLVED/FAILED only)
//   submit              : player declares the drawing finished
//   tick                : countdown timebase pulse
//   kb_valid/kb_addr    : key press and the cell it targets
//   pen_color           : color painted by a key press
//   correct             : puzzle match flag from the paper
//   seed                : {shape, color1, color2}, stable for the round
//   wr_en/wr_addr/wr_color : paper write port
//   time_left, strikes  : round timer and wrong-submission count
//   busy, solved, failed: round status levels
// All outputs are registered.
module draw_round_ctrl
  import draw_pkg::*;
#(
  parameter int         TIME_LIMIT  = 60,
  parameter int         MAX_STRIKES = 3,
  parameter logic [7:0] LFSR_INIT   = 8'hA5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic               submit,
  input  logic               tick,
  input  logic               kb_valid,
  input  logic [CELL_W-1:0]  kb_addr,
  input  logic [COLOR_W-1:0] pen_color,
  input  logic               correct,
  output logic [7:0]         seed,
  output logic               wr_en,
  output logic [CELL_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_color,
  output logic [7:0]         time_left,
  output logic [1:0]         strikes,
  output logic               busy,
  output logic               solved,
  output logic               failed
);

  localparam logic [7:0] TL8 = 8'(TIME_LIMIT);
  localparam logic [1:0] MS2 = 2'(MAX_STRIKES);

  // Judge on the third CHECK cycle so a paint issued with submit has landed.
  localparam logic [1:0] CHK_LAST = 2'd2;

  state_t             state, state_nxt;
  logic [CELL_W-1:0]  clr_cnt, clr_d;
  logic [1:0]         chk_cnt, chk_d;
  logic [7:0]         lfsr_q;

  logic [7:0]         seed_d;
  logic               wr_en_d;
  logic [CELL_W-1:0]  wr_addr_d;
  logic [COLOR_W-1:0] wr_color_d;
  logic [7:0]         time_d;
  logic [1:0]         strikes_d;

  logic               tick_zero;
  logic               judge;
  logic [1:0]         strike_inc;
  logic               seed_good;

  round_lfsr #(.INIT(LFSR_INIT)) u_lfsr (
    .Clk (Clk),
    .Rst (Rst),
    .q   (lfsr_q)
  );

  assign seed_good  = seed_ok(lfsr_q);
  assign strike_inc = strikes + 2'd1;
  // The tick that takes the timer to zero beats a same-cycle submit.
  assign tick_zero  = (state == ST_PLAY) && tick && (time_left == 8'd1);
  assign judge      = (state == ST_CHECK) && (chk_cnt == CHK_LAST);

  // ---- state register and output registers ----
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      chk_cnt   <= '0;
      seed      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_color  <= '0;
      time_left <= '0;
      strikes   <= '0;
      busy      <= 1'b0;
      solved    <= 1'b0;
      failed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_d;
      chk_cnt   <= chk_d;
      seed      <= seed_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_color  <= wr_color_d;
      time_left <= time_d;
      strikes   <= strikes_d;
      // Status flags follow the state being entered so they line up with it.
      busy      <= (state_nxt == ST_CLEAR) || (state_nxt == ST_SEED) ||
                   (state_nxt == ST_PLAY)  || (state_nxt == ST_CHECK);
      solved    <= (state_nxt == ST_SOLVED);
      failed    <= (state_nxt == ST_FAILED);
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_SOLVED, ST_FAILED:
        if (start) state_nxt = ST_CLEAR;
      ST_CLEAR:
        if (clr_cnt == CELL_W'(NUM_CELLS - 1)) state_nxt = ST_SEED;
      ST_SEED:
        if (seed_good) state_nxt = ST_PLAY;
      ST_PLAY:
        if (tick_zero)   state_nxt = ST_FAILED;
        else if (submit) state_nxt = ST_CHECK;
      ST_CHECK:
        if (judge) begin
          if (correct)                state_nxt = ST_SOLVED;
          else if (strike_inc == MS2) state_nxt = ST_FAILED;
          else                        state_nxt = ST_PLAY;
        end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- datapath / output next values ----
  always_comb begin
    clr_d      = clr_cnt;
    chk_d      = 2'd0;
    seed_d     = seed;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_color_d = wr_color;
    time_d     = time_left;
    strikes_d  = strikes;
    case (state)
      ST_IDLE, ST_SOLVED, ST_FAILED: begin
        // The first clear write goes out with the start edge so the sweep
        // covers exactly the 16 cycles after start.
        if (start) begin
          strikes_d  = '0;
          clr_d      = '0;
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_color_d = BLANK;
        end
      end
      ST_CLEAR: begin
        // clr_cnt tracks the address currently on the write port.
        if (clr_cnt != CELL_W'(NUM_CELLS - 1)) begin
          clr_d      = clr_cnt + CELL_W'(1);
          wr_en_d    = 1'b1;
          wr_addr_d  = clr_cnt + CELL_W'(1);
          wr_color_d = BLANK;
        end
      end
      ST_SEED: begin
        if (seed_good) begin
          seed_d = lfsr_q;
          time_d = TL8;
        end
      end
      ST_PLAY: begin
        if (kb_valid) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = kb_addr;
          wr_color_d = pen_color;
        end
        if (tick) time_d = time_left - 8'd1;
      end
      ST_CHECK: begin
        chk_d = chk_cnt + 2'd1;
        if (judge && !correct) strikes_d = strike_inc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_round_ctrl.sv
module tb_draw_round_ctrl;

  localparam int         TL   = 3;
  localparam int         MS   = 2;
  localparam logic [7:0] INIT = 8'hA5;

  logic       Clk = 1'b0;
  logic       Rst, start, submit, tick, kb_valid, correct;
  logic [3:0] kb_addr;
  logic [2:0] pen_color;
  logic [7:0] seed, time_left;
  logic       wr_en, busy, solved, failed;
  logic [3:0] wr_addr;
  logic [2:0] wr_color;
  logic [1:0] strikes;

  draw_round_ctrl #(.TIME_LIMIT(TL), .MAX_STRIKES(MS), .LFSR_INIT(INIT)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .submit(submit), .tick(tick),
    .kb_valid(kb_valid), .kb_addr(kb_addr), .pen_color(pen_color),
    .correct(correct), .seed(seed), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_color(wr_color), .time_left(time_left), .strikes(strikes),
    .busy(busy), .solved(solved), .failed(failed)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_CLEAR, P_SEED, P_PLAY, P_CHECK, P_SOLVED, P_FAILED} phase_t;
  phase_t     ph;
  logic [7:0] m_lfsr, m_seed, m_time;
  int         m_strk, clears_left, check_left;
  logic       e_wr_en;
  logic [3:0] e_wr_addr;
  logic [2:0] e_wr_color;

  // x^8+x^6+x^5+x^4+1: new bit = b7^b5^b4^b3, shifted in at the bottom
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic bit usable(input logic [7:0] v);
    return (v[5:3] != 0) && (v[2:0] != 0) && (v[5:3] != v[2:0]);
  endfunction

  task automatic emit(input logic [3:0] a, input logic [2:0] c);
    e_wr_en = 1'b1; e_wr_addr = a; e_wr_color = c;
  endtask

  // Applied at every rising edge with the inputs of the cycle just ending;
  // produces what the outputs must show for the following cycle.
  task automatic model_step();
    if (Rst) begin
      ph = P_IDLE; m_lfsr = INIT; m_seed = 0; m_time = 0; m_strk = 0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_color = 0;
      return;
    end
    e_wr_en = 0;
    case (ph)
      P_IDLE, P_SOLVED, P_FAILED:
        if (start) begin
          ph = P_CLEAR; m_strk = 0; clears_left = 15;
          emit(4'd0, 3'd0);
        end
      P_CLEAR:
        if (clears_left == 0) ph = P_SEED;
        else begin
          emit(4'(16 - clears_left), 3'd0);
          clears_left--;
        end
      P_SEED:
        if (usable(m_lfsr)) begin
          m_seed = m_lfsr; m_time = 8'(TL); ph = P_PLAY;
        end
      P_PLAY: begin
        if (kb_valid) emit(kb_addr, pen_color);
        if (tick) m_time = m_time - 8'd1;
        if (tick && m_time == 0) ph = P_FAILED;
        else if (submit) begin ph = P_CHECK; check_left = 3; end
      end
      P_CHECK: begin
        check_left--;
        if (check_left == 0) begin
          if (correct) ph = P_SOLVED;
          else begin
            m_strk++;
            ph = (m_strk == MS) ? P_FAILED : P_PLAY;
          end
        end
      end
      default: ;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    bit e_busy;
    e_busy = (ph == P_CLEAR) || (ph == P_SEED) || (ph == P_PLAY) || (ph == P_CHECK);
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
      chk("wr_color", 32'(wr_color), 32'(e_wr_color));
    end
    chk("seed", 32'(seed), 32'(m_seed));
    chk("time_left", 32'(time_left), 32'(m_time));
    chk("strikes", 32'(strikes), 32'(m_strk));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("solved", 32'(solved), 32'(ph == P_SOLVED));
    chk("failed", 32'(failed), 32'(ph == P_FAILED));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    start = 0; submit = 0; tick = 0; kb_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic wait_play();
    for (int i = 0; i < 60 && ph != P_PLAY; i++) cycle();
    chk("reach_play", 32'(busy && ph == P_PLAY), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] tl_hold;
    Rst = 1; correct = 0; kb_addr = 0; pen_color = 0;
    quiet();
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_seed", 32'(seed), 32'd0);
    Rst = 0;
    for (int i = 3; i < 10; i++) cycle();

    // round start: 16 clear writes then seed/play
    pulse_start();
    chk("clr_first_addr", 32'(wr_addr), 32'd0);
    wait_play();
    chk("seed_c1_nz", 32'(seed[5:3] != 0), 32'd1);
    chk("seed_c2_nz", 32'(seed[2:0] != 0), 32'd1);
    chk("seed_c_diff", 32'(seed[5:3] != seed[2:0]), 32'd1);

    // paint in PLAY
    kb_valid = 1; kb_addr = 4'd5; pen_color = 3'd3;
    cycle(); kb_valid = 0;
    chk("kb_wr_addr", 32'(wr_addr), 32'd5);
    chk("kb_wr_color", 32'(wr_color), 32'd3);
    cycle();
    chk("kb_one_shot", 32'(wr_en), 32'd0);

    // countdown to fail
    for (int i = 0; i < TL; i++) begin
      tick = 1; cycle(); tick = 0;
      chk("tick_time", 32'(time_left), 32'(TL - 1 - i));
      cycle();
    end
    chk("tick_failed", 32'(failed), 32'd1);
    chk("tick_busy", 32'(busy), 32'd0);

    // paint outside PLAY is dropped
    kb_valid = 1; cycle(); kb_valid = 0;
    chk("kb_dropped", 32'(wr_en), 32'd0);

    // two wrong submits
    pulse_start(); wait_play();
    correct = 0;
    submit = 1; cycle(); submit = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("strike1", 32'(strikes), 32'd1);
    submit = 1; cycle(); submit = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("strike_fail", 32'(failed), 32'd1);
    chk("strike_cnt", 32'(strikes), 32'd2);

    // submit with paint, correct rises two cycles later
    pulse_start(); wait_play();
    submit = 1; kb_valid = 1; kb_addr = 4'd9; pen_color = 3'd6;
    cycle(); quiet();
    chk("sub_wr", 32'(wr_en), 32'd1);
    cycle();
    correct = 1;
    cycle();
    chk("not_yet_solved", 32'(solved), 32'd0);
    cycle();
    chk("solved", 32'(solved), 32'd1);
    correct = 0;
    tl_hold = time_left;
    tick = 1; cycle(); tick = 0;
    chk("solved_time_hold", 32'(time_left), 32'(tl_hold));

    // reset in the middle of the clear sweep
    pulse_start();
    for (int i = 0; i < 7; i++) cycle();
    chk("clr_addr7", 32'(wr_addr), 32'd7);
    Rst = 1; cycle(); Rst = 0;
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    pulse_start();
    chk("restart_addr0", 32'(wr_addr), 32'd0);
    chk("restart_wr_en", 32'(wr_en), 32'd1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      start     = ($urandom_range(0, 39) == 0);
      submit    = ($urandom_range(0, 11) == 0);
      tick      = ($urandom_range(0, 9) == 0);
      kb_valid  = ($urandom_range(0, 2) == 0);
      kb_addr   = 4'($urandom);
      pen_color = 3'($urandom);
      correct   = ($urandom_range(0, 2) == 0);
      Rst       = ($urandom_range(0, 599) == 0);
      cycle();
    end
    Rst = 0; quiet();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_round_ctrl.md
# draw_round_ctrl

Round sequencer for the drawing puzzle. It owns the paper write port and clears all 16 cells at round start. It generates the 8-bit puzzle seed (shape select plus two colors) from an internal LFSR and forwards keypad paints only while a round is live. It runs the countdown and judges submissions against the puzzle's `correct` flag, counting strikes until the round is solved or failed.

## Interface
Parameters:
- TIME_LIMIT, 60: round length in `tick` pulses; must be 1..255.
- MAX_STRIKES, 3: wrong submissions allowed before fail; must be 1..3.
- LFSR_INIT, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- Clk  in  1  system clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a round.
- submit  in  1  one-cycle pulse: player declares the drawing finished.
- tick  in  1  one-cycle timebase pulse (nominally 1 Hz).
- kb_valid  in  1  one-cycle pulse: a key was pressed.
- kb_addr  in  4  cell index of the pressed key (0..15).
- pen_color  in  3  currently selected pen color.
- correct  in  1  puzzle match flag; combinational from the painted paper.
- seed  out  8  [7:6] shape, [5:3] color1, [2:0] color2; held stable for the whole round.
- wr_en  out  1  paper write strobe.
- wr_addr  out  4  paper cell index.
- wr_color  out  3  color to write.
- time_left  out  8  remaining ticks.
- strikes  out  2  wrong submissions this round.
- busy  out  1  high in CLEAR, SEED, PLAY and CHECK.
- solved  out  1  level, high in SOLVED.
- failed  out  1  level, high in FAILED.

## Operation
- States: IDLE, CLEAR, SEED, PLAY, CHECK, SOLVED, FAILED.
- IDLE/SOLVED/FAILED, on `start`: go to CLEAR; strikes := 0; clear counter := 0; solved and failed drop. `start` is ignored in every other state.
- CLEAR: one write per cycle, with wr_addr = counter and wr_color = BLANK (3'b000). Covers 16 cycles, addresses 0..15 ascending. After address 15 go to SEED.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Steps every cycle in every state and is never all-zero.
- SEED: capture the LFSR value into `seed` only if [5:3] != 0, [2:0] != 0, and [5:3] != [2:0]. Otherwise stay in SEED and retry next cycle. On capture: time_left := TIME_LIMIT, go to PLAY.
- PLAY, on `kb_valid`: wr_en=1, wr_addr=kb_addr, wr_color=pen_color. `kb_valid` outside PLAY is dropped.
- PLAY, on `tick`: time_left decrements. When it reaches 0, go to FAILED.
- PLAY, on `submit`: go to CHECK.
- Simultaneous events in PLAY:
  - `kb_valid` with `submit`: the write is still issued.
  - `tick` to 0 with `submit`: FAILED wins.
- CHECK: holds 3 cycles so any write issued on the submit cycle has landed in paper before judging. The timer is frozen.
  - On cycle 3, `correct` = 1: go to SOLVED.
  - Otherwise strikes += 1. If the new value == MAX_STRIKES, go to FAILED; else go to PLAY.
- SOLVED/FAILED: seed, time_left and strikes hold until the next `start`.

## Timing
- Reset values: state IDLE, LFSR LFSR_INIT, and every output 0 (seed, wr_en, wr_addr, wr_color, time_left, strikes, busy, solved, failed).
- All outputs are registered.
- Write latency: wr_* are asserted the cycle after `kb_valid`. wr_en is high for exactly one cycle per accepted key.
- Round startup: `start` at cycle t puts CLEAR writes on cycles t+1..t+16. SEED is entered at t+17 and PLAY no earlier than t+18.
- Judging: `submit` at t puts the state in CHECK for t+1..t+3; `correct` is sampled at t+3. The outcome state is visible at t+4.
- Rst asserted in any state, including mid-CLEAR: next cycle returns to IDLE with wr_en=0. Paper contents are then undefined until the next CLEAR.
- `tick` is counted only in PLAY.

## Structure
- Package `draw_pkg` holds:
  - the state enum;
  - BLANK = 3'b000;
  - color width 3 and cell-index width 4;
  - the LFSR tap mask 8'hB8;
  - the seed field positions.
- Sub-module `round_lfsr` (8-bit, loadable init, always-enabled step). The FSM, clear counter, timer and strike counter stay in the top module.

## Test plan
- Reset, then `start` at cycle 10 → wr_en high on cycles 11..26 with wr_addr 0..15, wr_color 0; busy=1; afterwards seed[5:3] and seed[2:0] are non-zero and distinct.
- In PLAY, `kb_valid` with kb_addr=5 and pen_color=3 → exactly one cycle later wr_en=1, wr_addr=5, wr_color=3. The same pulse in IDLE → no write.
- TIME_LIMIT=3, three `tick` pulses in PLAY with no submit → time_left steps 3, 2, 1, 0, then failed=1 and busy=0.
- MAX_STRIKES=2, `correct` held 0, two `submit` pulses → strikes 1 after the first, then failed=1 with strikes=2.
- `correct` driven to 1 two cycles after a `submit` that coincides with a `kb_valid` → solved=1 four cycles after submit; a further `tick` does not change time_left.
- Rst asserted at CLEAR address 7 → next cycle state IDLE and wr_en=0. A new `start` restarts the clear at address 0.
